// File: rtl/rx_block_lock_if.sv
// rx_block_lock_if
//   Groups the block stream coming from the RX gearbox and the block-lock
//   results going back to the gearbox and on to the descrambler/decoder.
//
//   Signals:
//     data_in    [65:0]  block from gearbox, [1:0] = sync header (bit 0 first)
//     valid_in           data_in carries a new block this cycle
//     bitslip            one-cycle pulse asking the gearbox to shift by one bit
//     data_out   [65:0]  registered copy of data_in
//     valid_out          data_out valid and block lock asserted
//     block_lock         lock status
//     slip_count [7:0]   saturating count of bitslips since reset
//
//   Modports:
//     master  gearbox / stream source side
//     slave   block-lock stage side
interface rx_block_lock_if;
  logic [65:0] data_in;
  logic        valid_in;
  logic        bitslip;
  logic [65:0] data_out;
  logic        valid_out;
  logic        block_lock;
  logic [7:0]  slip_count;

  modport master (
    output data_in, valid_in,
    input  bitslip, data_out, valid_out, block_lock, slip_count
  );

  modport slave (
    input  data_in, valid_in,
    output bitslip, data_out, valid_out, block_lock, slip_count
  );
endinterface

// File: rtl/rx_block_lock.sv
// rx_block_lock
//   64B/66B block-lock stage sitting right after the RX gearbox. It checks the
//   sync header of every block, pulses bitslip until block boundaries are
//   found, applies lock/unlock hysteresis and forwards blocks only while
//   locked.
//
//   Ports:
//     clk    gearbox output clock
//     reset  synchronous, active-high reset
//     bus    rx_block_lock_if.slave (block stream in, lock results out)
module rx_block_lock #(
  parameter int LOCK_CNT  = 64,    // consecutive good headers to declare lock
  parameter int WINDOW    = 1024,  // headers per monitoring window while locked
  parameter int BAD_MAX   = 65,    // bad headers per window that drop lock
  parameter int SLIP_WAIT = 4      // blocks discarded after each bitslip
) (
  input  logic           clk,
  input  logic           reset,
  rx_block_lock_if.slave bus
);

  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [10:0]       LOCK_CNT_V  = 11'(LOCK_CNT);
  localparam logic [10:0]       WINDOW_V    = 11'(WINDOW);
  localparam logic [6:0]        BAD_MAX_V   = 7'(BAD_MAX);
  localparam logic [WAIT_W-1:0] SLIP_WAIT_V = WAIT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_TEST = 2'd0,
    ST_SLIP = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       sh_cnt_q, sh_cnt_d;
  logic [6:0]        bad_cnt_q, bad_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]        slip_cnt_q, slip_cnt_d;
  logic              block_lock_q, block_lock_d;
  logic              bitslip_q;
  logic              valid_out_q;
  logic [65:0]       data_out_q;

  logic              sh_valid;
  logic [10:0]       sh_inc;
  logic [6:0]        bad_inc;
  logic [WAIT_W-1:0] wait_inc;

  assign sh_valid = (bus.data_in[1:0] == 2'b01) || (bus.data_in[1:0] == 2'b10);
  assign sh_inc   = sh_cnt_q + 11'd1;
  assign bad_inc  = bad_cnt_q + {6'd0, ~sh_valid};
  assign wait_inc = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    block_lock_d = block_lock_q;

    case (state_q)
      ST_TEST: begin
        if (bus.valid_in) begin
          if (!block_lock_q) begin
            // Hunting: any bad header means the alignment is wrong.
            if (!sh_valid) begin
              state_d   = ST_SLIP;
              sh_cnt_d  = '0;
              bad_cnt_d = '0;
            end else if (sh_inc == LOCK_CNT_V) begin
              block_lock_d = 1'b1;
              sh_cnt_d     = '0;
              bad_cnt_d    = '0;
            end else begin
              sh_cnt_d = sh_inc;
            end
          end else begin
            // Locked: loss of lock wins over the end of the window.
            if (bad_inc == BAD_MAX_V) begin
              block_lock_d = 1'b0;
              state_d      = ST_SLIP;
              sh_cnt_d     = '0;
              bad_cnt_d    = '0;
            end else if (sh_inc == WINDOW_V) begin
              sh_cnt_d  = '0;
              bad_cnt_d = '0;
            end else begin
              sh_cnt_d  = sh_inc;
              bad_cnt_d = bad_inc;
            end
          end
        end
      end

      ST_SLIP: begin
        // Lasts exactly one cycle whatever valid_in does.
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
        if (slip_cnt_q != 8'hFF) begin
          slip_cnt_d = slip_cnt_q + 8'd1;
        end
      end

      ST_WAIT: begin
        // Blocks still in flight through the gearbox are dropped unexamined.
        if (bus.valid_in) begin
          if (wait_inc == SLIP_WAIT_V) begin
            state_d    = ST_TEST;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
      end

      default: begin
        state_d = ST_TEST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_TEST;
      sh_cnt_q     <= '0;
      bad_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      slip_cnt_q   <= '0;
      block_lock_q <= 1'b0;
      bitslip_q    <= 1'b0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      block_lock_q <= block_lock_d;
      // Registered so the pulse is high for exactly the cycle spent in SLIP.
      bitslip_q    <= (state_d == ST_SLIP);
      valid_out_q  <= bus.valid_in && block_lock_d;
      data_out_q   <= bus.data_in;
    end
  end

  assign bus.bitslip    = bitslip_q;
  assign bus.data_out   = data_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.block_lock = block_lock_q;
  assign bus.slip_count = slip_cnt_q;

endmodule
